// File: rtl/pipeline_pkg.sv
// Shared types and encodings for the pipeline hazard/stall controller.
package pipeline_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational register-match logic: load-use, RAW stall and forward selects.
// Define FORWARDING_EN to forward from M/W; otherwise RAW hazards on E/M stall decode.
module hazard_detect
    import pipeline_pkg::*;
#(
    parameter int REGISTER_ADDRESS_WIDTH = 5
) (
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] i_rs1d,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] i_rs2d,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] i_rs1e,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] i_rs2e,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] i_rde,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] i_rdm,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] i_rdw,
    input  logic                              i_reg_write_e,
    input  logic                              i_reg_write_m,
    input  logic                              i_reg_write_w,
    input  logic [1:0]                        i_result_src_e,
    output logic                              o_load_use,
    output logic                              o_raw_stall,
    output logic [1:0]                        o_fwd_a,
    output logic [1:0]                        o_fwd_b
);

    localparam int W = REGISTER_ADDRESS_WIDTH;

    // Register 0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic reg_hit(input logic [W-1:0] rd, input logic [W-1:0] rs,
                                     input logic we);
        return we && (rd != '0) && (rd == rs);
    endfunction

    assign o_load_use = (i_result_src_e == RESULT_SRC_LOAD) &&
                        (reg_hit(i_rde, i_rs1d, 1'b1) || reg_hit(i_rde, i_rs2d, 1'b1));

`ifdef FORWARDING_EN
    function automatic logic [1:0] fwd_sel(input logic [W-1:0] rs);
        if (reg_hit(i_rdm, rs, i_reg_write_m))
            return FWD_M;
        else if (reg_hit(i_rdw, rs, i_reg_write_w))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

    logic w_unused_fwd;

    assign o_fwd_a      = fwd_sel(i_rs1e);
    assign o_fwd_b      = fwd_sel(i_rs2e);
    assign o_raw_stall  = 1'b0;
    assign w_unused_fwd = i_reg_write_e;
`else
    logic w_unused_fwd;

    assign o_fwd_a     = FWD_RF;
    assign o_fwd_b     = FWD_RF;
    // W needs no stall: the register file writes before it is read.
    assign o_raw_stall = reg_hit(i_rde, i_rs1d, i_reg_write_e) ||
                         reg_hit(i_rde, i_rs2d, i_reg_write_e) ||
                         reg_hit(i_rdm, i_rs1d, i_reg_write_m) ||
                         reg_hit(i_rdm, i_rs2d, i_reg_write_m);
    assign w_unused_fwd = ^{i_rs1e, i_rs2e, i_rdw, i_reg_write_w};
`endif

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control: memory-wait FSM, freeze/flush/stall priority, stall counter.
// Forwarding vs. RAW-stall behaviour is selected in hazard_detect by FORWARDING_EN.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int REGISTER_ADDRESS_WIDTH = 5
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i,
    input  logic                              RegWriteE_i,
    input  logic                              RegWriteM_i,
    input  logic                              RegWriteW_i,
    input  logic [1:0]                        ResultSrcE_i,
    input  logic                              PCSrcE_i,
    input  logic                              MemReqM_i,
    input  logic                              MemReadyM_i,
    output logic                              StallF_o,
    output logic                              StallD_o,
    output logic                              FlushD_o,
    output logic                              FlushE_o,
    output logic                              EnM_o,
    output logic                              EnW_o,
    output logic [1:0]                        ForwardAE_o,
    output logic [1:0]                        ForwardBE_o,
    output logic [31:0]                       stall_count_o
);

    state_t      r_state;
    logic        r_branch_pending;
    logic [31:0] r_stall_count;

    logic w_load_use;
    logic w_raw_stall;
    logic w_freeze;
    logic w_branch;

    hazard_detect #(
        .REGISTER_ADDRESS_WIDTH(REGISTER_ADDRESS_WIDTH)
    ) u_hazard_detect (
        .i_rs1d         (Rs1D_i),
        .i_rs2d         (Rs2D_i),
        .i_rs1e         (Rs1E_i),
        .i_rs2e         (Rs2E_i),
        .i_rde          (RdE_i),
        .i_rdm          (RdM_i),
        .i_rdw          (RdW_i),
        .i_reg_write_e  (RegWriteE_i),
        .i_reg_write_m  (RegWriteM_i),
        .i_reg_write_w  (RegWriteW_i),
        .i_result_src_e (ResultSrcE_i),
        .o_load_use     (w_load_use),
        .o_raw_stall    (w_raw_stall),
        .o_fwd_a        (ForwardAE_o),
        .o_fwd_b        (ForwardBE_o)
    );

    // The pipe is held until the acknowledge arrives; the ack cycle itself advances.
    assign w_freeze = (MemReqM_i || (r_state == ST_MEM_WAIT)) && !MemReadyM_i;
    assign w_branch = !w_freeze && (PCSrcE_i || r_branch_pending);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        StallF_o = 1'b0;
        StallD_o = 1'b0;
        FlushD_o = 1'b0;
        FlushE_o = 1'b0;
        EnM_o    = 1'b1;
        EnW_o    = 1'b1;
        if (w_freeze) begin
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            EnM_o    = 1'b0;
            EnW_o    = 1'b0;
        end else if (w_branch) begin
            FlushD_o = 1'b1;
            FlushE_o = 1'b1;
        end else if (w_load_use || w_raw_stall) begin
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            FlushE_o = 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state          <= ST_RUN;
            r_branch_pending <= 1'b0;
            r_stall_count    <= '0;
        end else begin
            case (r_state)
                ST_RUN:      if (MemReqM_i && !MemReadyM_i) r_state <= ST_MEM_WAIT;
                ST_MEM_WAIT: if (MemReadyM_i) r_state <= ST_RUN;
                default:     r_state <= ST_RUN;
            endcase
            r_branch_pending <= w_freeze && (PCSrcE_i || r_branch_pending);
            if (StallF_o && (r_stall_count != 32'hFFFF_FFFF))
                r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stall_count_o = r_stall_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: driver queues expected outputs, negedge monitor compares.
module tb_pipeline_ctrl;

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwe, rwm, rww;
        logic [1:0] rsrc;
        logic       pcsrc, memreq, memrdy;
    } vin_t;

    typedef struct {
        int          id;
        logic        stallf, stalld, flushd, flushe, enm, enw;
        logic [1:0]  fwda, fwdb;
        logic [31:0] cnt;
    } vexp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i;
    logic        RegWriteE_i, RegWriteM_i, RegWriteW_i;
    logic [1:0]  ResultSrcE_i;
    logic        PCSrcE_i, MemReqM_i, MemReadyM_i;
    logic        StallF_o, StallD_o, FlushD_o, FlushE_o, EnM_o, EnW_o;
    logic [1:0]  ForwardAE_o, ForwardBE_o;
    logic [31:0] stall_count_o;

    int          n_checks = 0;
    int          n_errors = 0;
    int          step_id  = 0;
    logic [31:0] exp_count = 0;
    vexp_t       sb_q[$];
    vexp_t       m_e;
    vin_t        v;
    vexp_t       e;

    always #5 clk_i = ~clk_i;

    pipeline_ctrl #(.REGISTER_ADDRESS_WIDTH(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .Rs1D_i(Rs1D_i), .Rs2D_i(Rs2D_i), .Rs1E_i(Rs1E_i), .Rs2E_i(Rs2E_i),
        .RdE_i(RdE_i), .RdM_i(RdM_i), .RdW_i(RdW_i),
        .RegWriteE_i(RegWriteE_i), .RegWriteM_i(RegWriteM_i), .RegWriteW_i(RegWriteW_i),
        .ResultSrcE_i(ResultSrcE_i), .PCSrcE_i(PCSrcE_i),
        .MemReqM_i(MemReqM_i), .MemReadyM_i(MemReadyM_i),
        .StallF_o(StallF_o), .StallD_o(StallD_o), .FlushD_o(FlushD_o), .FlushE_o(FlushE_o),
        .EnM_o(EnM_o), .EnW_o(EnW_o),
        .ForwardAE_o(ForwardAE_o), .ForwardBE_o(ForwardBE_o),
        .stall_count_o(stall_count_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vin_t idle();
        vin_t r;
        r = '{default: '0};
        return r;
    endfunction

    function automatic vexp_t mk(input logic sf, input logic sd, input logic fd,
                                 input logic fe, input logic en);
        vexp_t r;
        r = '{id: 0, stallf: sf, stalld: sd, flushd: fd, flushe: fe, enm: en, enw: en,
              fwda: 2'b00, fwdb: 2'b00, cnt: 32'd0};
        return r;
    endfunction

    function automatic vexp_t e_run();    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); endfunction
    function automatic vexp_t e_stall();  return mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1); endfunction
    function automatic vexp_t e_flush();  return mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1); endfunction
    function automatic vexp_t e_freeze(); return mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); endfunction

    // Apply one cycle of inputs; the expected stall_count is the tally of earlier stall cycles.
    task automatic step(input vin_t vi, input vexp_t ex, input bit rst_pulse);
        @(posedge clk_i);
        #1;
        Rs1D_i = vi.rs1d; Rs2D_i = vi.rs2d; Rs1E_i = vi.rs1e; Rs2E_i = vi.rs2e;
        RdE_i = vi.rde; RdM_i = vi.rdm; RdW_i = vi.rdw;
        RegWriteE_i = vi.rwe; RegWriteM_i = vi.rwm; RegWriteW_i = vi.rww;
        ResultSrcE_i = vi.rsrc; PCSrcE_i = vi.pcsrc;
        MemReqM_i = vi.memreq; MemReadyM_i = vi.memrdy;
        if (rst_pulse) begin
            rst_i = 1'b1;
            #2;
            rst_i = 1'b0;
            exp_count = 0;
        end
        ex.id  = step_id;
        ex.cnt = exp_count;
        sb_q.push_back(ex);
        if (ex.stallf) exp_count = exp_count + 1;
        step_id++;
    endtask

    always @(negedge clk_i) begin
        if (sb_q.size() > 0) begin
            m_e = sb_q.pop_front();
            check($sformatf("s%0d.StallF", m_e.id), {31'd0, StallF_o}, {31'd0, m_e.stallf});
            check($sformatf("s%0d.StallD", m_e.id), {31'd0, StallD_o}, {31'd0, m_e.stalld});
            check($sformatf("s%0d.FlushD", m_e.id), {31'd0, FlushD_o}, {31'd0, m_e.flushd});
            check($sformatf("s%0d.FlushE", m_e.id), {31'd0, FlushE_o}, {31'd0, m_e.flushe});
            check($sformatf("s%0d.EnM", m_e.id), {31'd0, EnM_o}, {31'd0, m_e.enm});
            check($sformatf("s%0d.EnW", m_e.id), {31'd0, EnW_o}, {31'd0, m_e.enw});
            check($sformatf("s%0d.ForwardAE", m_e.id), {30'd0, ForwardAE_o}, {30'd0, m_e.fwda});
            check($sformatf("s%0d.ForwardBE", m_e.id), {30'd0, ForwardBE_o}, {30'd0, m_e.fwdb});
            check($sformatf("s%0d.stall_count", m_e.id), stall_count_o, m_e.cnt);
        end
    end

    initial begin
        v = idle();
        rst_i = 1'b1;
        {Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i} = '0;
        {RegWriteE_i, RegWriteM_i, RegWriteW_i} = '0;
        ResultSrcE_i = 2'b00; PCSrcE_i = 1'b0; MemReqM_i = 1'b0; MemReadyM_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #2 rst_i = 1'b0;

        // s0: state after reset
        step(idle(), e_run(), 1'b0);

        // s1: M and W both write x5, E reads x5 -> M has priority
        v = idle(); v.rdm = 5; v.rwm = 1; v.rdw = 5; v.rww = 1; v.rs1e = 5; v.rs2e = 9;
        e = e_run();
`ifdef FORWARDING_EN
        e.fwda = 2'b10;
`endif
        step(v, e, 1'b0);

        // s2: same with RdM=0 -> W source
        v.rdm = 0;
        e = e_run();
`ifdef FORWARDING_EN
        e.fwda = 2'b01;
`endif
        step(v, e, 1'b0);

        // s3: M match without RegWriteM falls through to W on operand B
        v = idle(); v.rdm = 6; v.rwm = 0; v.rdw = 6; v.rww = 1; v.rs2e = 6;
        e = e_run();
`ifdef FORWARDING_EN
        e.fwdb = 2'b01;
`endif
        step(v, e, 1'b0);

        // s4: register 0 never forwards
        v = idle(); v.rwm = 1; v.rww = 1;
        step(v, e_run(), 1'b0);

        // s5: load-use on Rs2D
        v = idle(); v.rsrc = 2'b01; v.rde = 7; v.rwe = 1; v.rs2d = 7; v.rs1d = 2;
        step(v, e_stall(), 1'b0);

        // s6: stall lasts one cycle once E is flushed
        step(idle(), e_run(), 1'b0);

        // s7: load to x0 is no hazard
        v = idle(); v.rsrc = 2'b01; v.rwe = 1;
        step(v, e_run(), 1'b0);

        // s8: ALU result in E feeding Rs1D
        v = idle(); v.rde = 3; v.rwe = 1; v.rs1d = 3;
`ifdef FORWARDING_EN
        step(v, e_run(), 1'b0);
`else
        step(v, e_stall(), 1'b0);
`endif

        // s9: ALU result in M feeding Rs2D
        v = idle(); v.rdm = 4; v.rwm = 1; v.rs2d = 4;
`ifdef FORWARDING_EN
        step(v, e_run(), 1'b0);
`else
        step(v, e_stall(), 1'b0);
`endif

        // s10: branch beats load-use
        v = idle(); v.pcsrc = 1; v.rsrc = 2'b01; v.rde = 7; v.rwe = 1; v.rs1d = 7;
        step(v, e_flush(), 1'b0);

        // s11-s13: memory wait freezes everything, including the branch and load-use
        v.memreq = 1; v.memrdy = 0;
        repeat (3) step(v, e_freeze(), 1'b0);

        // s14: ack cycle releases the pipe and the branch flush applies
        v.memrdy = 1;
        step(v, e_flush(), 1'b0);

        // s15
        step(idle(), e_run(), 1'b0);

        // s16-s17: branch seen during freeze is applied after, even if PCSrcE drops
        v = idle(); v.pcsrc = 1; v.memreq = 1; v.memrdy = 0;
        step(v, e_freeze(), 1'b0);
        v.pcsrc = 0; v.memrdy = 1;
        step(v, e_flush(), 1'b0);

        // s18: pending branch consumed
        step(idle(), e_run(), 1'b0);

        // s19-s20: enter MEM_WAIT, which holds even after MemReqM drops
        v = idle(); v.memreq = 1; v.memrdy = 0;
        step(v, e_freeze(), 1'b0);
        step(idle(), e_freeze(), 1'b0);

        // s21: async reset during MEM_WAIT -> RUN, counter cleared
        step(idle(), e_run(), 1'b1);

        // s22
        step(idle(), e_run(), 1'b0);

        repeat (2) @(negedge clk_i);
        #1;
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
